sram_like_arbiter: RTL

Two-master to one-slave arbiter for the sram-like bus. It merges the core's instruction fetch port (IF stage) and data access port (EXE stage) into a single sram-like port toward the AXI bridge or the unified memory. It grants one request per accepted address handshake and holds the grant stable until the slave accepts. It records the owner of every outstanding transaction in an in-order FIFO so each `data_ok`/`rdata` beat returns to the master that issued it.

---
 rtl/sram_like_arbiter_if.sv | 30 +++
 rtl/sram_like_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: one sram-like bus port (request fields plus the
// addr_ok/data_ok handshakes and read data).
//   master modport : drives req/wr/size/wstrb/addr/wdata, receives addr_ok/data_ok/rdata
//   slave  modport : receives the request fields, drives addr_ok/data_ok/rdata
interface sram_like_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned STRB_W = 4;

    logic              req;
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: merges the instruction-fetch and data-access sram-like
// masters onto one sram-like slave port. A request that is presented but not
// yet accepted is locked so the slave sees stable fields; every accepted
// transaction records its owner (0 = inst, 1 = data) in an in-order FIFO that
// steers each returning data_ok beat back to the issuing master.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   inst_sram  slave side of the instruction master's sram-like port
//   data_sram  slave side of the data master's sram-like port
//   mem        master side toward the AXI bridge / unified memory
//
// Parameter:
//   OUTST_DEPTH  maximum accepted-but-unreturned transactions (power of two, 2..16)
//
// Build option:
//   SRAM_ARB_RR_EN  defined   -> round-robin between the two masters
//                   undefined -> fixed priority, data over inst
module sram_like_arbiter #(
    parameter int unsigned OUTST_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    sram_like_arbiter_if.slave         inst_sram,
    sram_like_arbiter_if.slave         data_sram,
    sram_like_arbiter_if.master        mem
);

    localparam int unsigned PTR_W = $clog2(OUTST_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(OUTST_DEPTH);

    logic                   lock_q, lock_d;
    logic                   lock_id_q, lock_id_d;
    logic [OUTST_DEPTH-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic sel;
    logic sel_req;
    logic full;
    logic not_empty;
    logic mem_req_c;
    logic push;
    logic pop;
    logic head_id;

    // Grant selection: a locked request keeps the grant until accepted.
`ifdef SRAM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        if (lock_q) begin
            sel = lock_id_q;
        end else if (inst_sram.req && data_sram.req) begin
            sel = ~last_q;
        end else begin
            sel = data_sram.req;
        end
    end

    // Last-grant tracking, updated on every accepted handshake.
    always_comb begin
        last_d = last_q;
        if (push) begin
            last_d = sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        if (lock_q) begin
            sel = lock_id_q;
        end else begin
            sel = data_sram.req;
        end
    end
`endif

    // Request path toward the slave.
    always_comb begin
        full      = (count_q == DEPTH_CNT);
        not_empty = (count_q != '0);
        sel_req   = sel ? data_sram.req : inst_sram.req;
        mem_req_c = sel_req & ~full & ~reset;
        push      = mem_req_c & mem.addr_ok;
        // A data_ok with nothing outstanding is a slave error and is dropped.
        pop       = mem.data_ok & not_empty & ~reset;
        head_id   = owner_q[rd_ptr_q];
    end

    always_comb begin
        mem.req   = mem_req_c;
        mem.wr    = sel ? data_sram.wr    : inst_sram.wr;
        mem.size  = sel ? data_sram.size  : inst_sram.size;
        mem.wstrb = sel ? data_sram.wstrb : inst_sram.wstrb;
        mem.addr  = sel ? data_sram.addr  : inst_sram.addr;
        mem.wdata = sel ? data_sram.wdata : inst_sram.wdata;
    end

    // Handshakes and response routing back to the masters.
    always_comb begin
        inst_sram.addr_ok = push & ~sel;
        data_sram.addr_ok = push &  sel;
        inst_sram.data_ok = pop  & ~head_id;
        data_sram.data_ok = pop  &  head_id;
        inst_sram.rdata   = mem.rdata;
        data_sram.rdata   = mem.rdata;
    end

    // Lock: hold the grant from the first unaccepted cycle until addr_ok.
    // While full, mem_req is low so the lock is simply retained.
    always_comb begin
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (push) begin
            lock_d = 1'b0;
        end else if (mem_req_c) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end
    end

    // Outstanding-owner FIFO; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        owner_d  = owner_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            owner_d[wr_ptr_q] = sel;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            owner_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            owner_q   <= owner_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule
